logistic_bank: RTL and testbench

Time-multiplexed bank of `CHANNELS` logistic-map iterators, x(n+1) = mu·x(n)·(1 − x(n)), sharing one arithmetic datapath.
- All channels iterate in round-robin for a programmable number of sweeps. Each channel starts from its own seed.
- Results are read back through an indexed port by the display/pixel logic.
- It is the parametrised successor of the fixed 7-instance, 17-bit iterator set: width, channel count and iteration-counter width are generic, and it adds a start/busy/done handshake.

---
 rtl/logistic_pkg.sv | 15 +
 rtl/logistic_step.sv | 28 ++
 rtl/logistic_bank.sv | 145 ++++++++++++++
 tb/tb_logistic_bank.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logistic_pkg.sv
// Shared types and defaults for the logistic-map iterator bank.
package logistic_pkg;

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    localparam int unsigned DefWidth    = 16;
    localparam int unsigned DefChannels = 7;
    localparam int unsigned DefIterW    = 9;

    // Fixed-point 1.0 for an unsigned Q1.width value
    function automatic longint unsigned one_of(input int unsigned width);
        return 64'(1) << width;
    endfunction

endpackage

// File: rtl/logistic_step.sv
// One logistic-map step y = mu*x*(1-x), unsigned Q1.WIDTH, truncating.
module logistic_step
    import logistic_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic [WIDTH:0]   x,
    input  logic [WIDTH+1:0] mu,
    output logic [WIDTH:0]   y
);

    localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(one_of(WIDTH));

    logic [WIDTH:0]       one_minus_x;
    logic [2*WIDTH+1:0]   p;
    logic [WIDTH+1:0]     t;
    logic [2*WIDTH+3:0]   prod;

    always_comb begin
        one_minus_x = ONE - x;
        p           = (2*WIDTH+2)'(x) * (2*WIDTH+2)'(one_minus_x);
        t           = (WIDTH + 2)'(p >> WIDTH);
        prod        = (2*WIDTH+4)'(mu) * (2*WIDTH+4)'(t);
        // Result stays below ONE for mu < 4, so plain truncation is safe
        y           = (WIDTH + 1)'(prod >> WIDTH);
    end

endmodule

// File: rtl/logistic_bank.sv
// Round-robin bank of logistic-map iterators sharing one logistic_step datapath.
// Optional trace outputs are enabled by defining LOGISTIC_TRACE_EN.
module logistic_bank
    import logistic_pkg::*;
#(
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned CHANNELS = DefChannels,
    parameter int unsigned ITER_W   = DefIterW,
    parameter int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [WIDTH+1:0]  mu,
    input  logic [ITER_W-1:0] times,
    input  logic [WIDTH:0]    x0_base,
    input  logic [WIDTH:0]    x0_step,
    output logic              busy,
    output logic              done,
    input  logic [CH_W-1:0]   rd_ch,
`ifdef LOGISTIC_TRACE_EN
    output logic              trace_valid,
    output logic [CH_W-1:0]   trace_ch,
    output logic [WIDTH:0]    trace_data,
`endif
    output logic [WIDTH:0]    rd_data
);

    localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(one_of(WIDTH));
    localparam int unsigned    SW  = WIDTH + 1 + CH_W;

    state_e            state_q, state_d;
    logic [WIDTH+1:0]  mu_q;
    logic [ITER_W-1:0] times_q;
    logic [CH_W-1:0]   ch_q;
    logic [ITER_W-1:0] sweep_q;
    logic [WIDTH:0]    x_q [CHANNELS];

    logic [SW-1:0]     seed_raw [CHANNELS];
    logic [WIDTH:0]    seed     [CHANNELS];
    logic [WIDTH:0]    x_cur, x_next;
    logic              last_ch, last_sweep;

    always_comb begin
        for (int i = 0; i < int'(CHANNELS); i++) begin
            seed_raw[i] = SW'(x0_base) + SW'(i) * SW'(x0_step);
            seed[i]     = (seed_raw[i] > SW'(ONE)) ? ONE : seed_raw[i][WIDTH:0];
        end
    end

    always_comb begin
        x_cur      = x_q[ch_q];
        last_ch    = (ch_q == CH_W'(CHANNELS - 1));
        last_sweep = ((sweep_q + ITER_W'(1)) == times_q);
    end

    logistic_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .x  (x_cur),
        .mu (mu_q),
        .y  (x_next)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) state_d = StLoad;
            end
            StLoad: state_d = (times_q != '0) ? StRun : StDone;
            StRun:  if (last_ch && last_sweep) state_d = StDone;
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mu_q    <= '0;
            times_q <= '0;
            ch_q    <= '0;
            sweep_q <= '0;
            for (int i = 0; i < int'(CHANNELS); i++) x_q[i] <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        mu_q    <= mu;
                        times_q <= times;
                    end
                end
                StLoad: begin
                    for (int i = 0; i < int'(CHANNELS); i++) x_q[i] <= seed[i];
                    ch_q    <= '0;
                    sweep_q <= '0;
                end
                StRun: begin
                    x_q[ch_q] <= x_next;
                    if (last_ch) begin
                        ch_q    <= '0;
                        sweep_q <= sweep_q + ITER_W'(1);
                    end else begin
                        ch_q    <= ch_q + CH_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LOGISTIC_TRACE_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            trace_valid <= 1'b0;
            trace_ch    <= '0;
            trace_data  <= '0;
        end else begin
            trace_valid <= (state_q == StRun);
            trace_ch    <= ch_q;
            trace_data  <= x_next;
        end
    end
`endif

    always_comb begin
        rd_data = '0;
        if (32'(rd_ch) < CHANNELS) rd_data = x_q[rd_ch];
    end

endmodule

// File: tb/tb_logistic_bank.sv
// Directed self-checking bench for logistic_bank (7-channel and 1-channel instances).
module tb_logistic_bank;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start7, start1;
    logic [17:0] mu;
    logic [8:0]  times;
    logic [16:0] x0_base, x0_step;
    logic [2:0]  rd_ch;
    logic        rd_ch1;
    logic        busy7, done7, busy1, done1;
    logic [16:0] rd7, rd1;
`ifdef LOGISTIC_TRACE_EN
    logic        tr_valid;
    logic [2:0]  tr_ch;
    logic [16:0] tr_data;
    logic        tr1_valid;
    logic        tr1_ch;
    logic [16:0] tr1_data;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    logistic_bank #(.WIDTH(16), .CHANNELS(7), .ITER_W(9)) dut7 (
        .CLK (CLK), .RST (RST), .start (start7), .mu (mu), .times (times),
        .x0_base (x0_base), .x0_step (x0_step), .busy (busy7), .done (done7),
        .rd_ch (rd_ch),
`ifdef LOGISTIC_TRACE_EN
        .trace_valid (tr_valid), .trace_ch (tr_ch), .trace_data (tr_data),
`endif
        .rd_data (rd7)
    );

    logistic_bank #(.WIDTH(16), .CHANNELS(1), .ITER_W(9)) dut1 (
        .CLK (CLK), .RST (RST), .start (start1), .mu (mu), .times (times),
        .x0_base (x0_base), .x0_step (x0_step), .busy (busy1), .done (done1),
        .rd_ch (rd_ch1),
`ifdef LOGISTIC_TRACE_EN
        .trace_valid (tr1_valid), .trace_ch (tr1_ch), .trace_data (tr1_data),
`endif
        .rd_data (rd1)
    );

    typedef struct {
        logic [17:0] mu;
        logic [8:0]  times;
        logic [16:0] base;
        logic [16:0] step;
        logic [2:0]  ch;
        logic [16:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns cycles from the start cycle to done
    task automatic run7(input vec_t v, output int lat);
        mu      = v.mu;
        times   = v.times;
        x0_base = v.base;
        x0_step = v.step;
        start7  = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start7 = 1'b0;
        lat    = 1;
        while (!done7 && lat < 500) begin
            @(negedge CLK);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int dones;
        vec_t v;

        // mu, times, base, step, ch, expected rd_data, done latency
        vecs[0]  = '{18'h20000, 9'd5, 17'd32768, 17'd0,     3'd3, 17'd32768, 37};
        vecs[1]  = '{18'h30000, 9'd0, 17'd65530, 17'd2,     3'd0, 17'd65530, 2};
        vecs[2]  = '{18'h30000, 9'd0, 17'd65530, 17'd2,     3'd1, 17'd65532, 2};
        vecs[3]  = '{18'h30000, 9'd0, 17'd65530, 17'd2,     3'd2, 17'd65534, 2};
        vecs[4]  = '{18'h30000, 9'd0, 17'd65530, 17'd2,     3'd3, 17'd65536, 2};
        vecs[5]  = '{18'h30000, 9'd0, 17'd65530, 17'd2,     3'd4, 17'd65536, 2};
        vecs[6]  = '{18'h30000, 9'd0, 17'd65530, 17'd2,     3'd5, 17'd65536, 2};
        vecs[7]  = '{18'h30000, 9'd0, 17'd65530, 17'd2,     3'd6, 17'd65536, 2};
        vecs[8]  = '{18'h30000, 9'd0, 17'd65530, 17'd2,     3'd7, 17'd0,     2};
        vecs[9]  = '{18'h30000, 9'd1, 17'd16384, 17'd16384, 3'd0, 17'd36864, 9};
        vecs[10] = '{18'h30000, 9'd1, 17'd16384, 17'd16384, 3'd1, 17'd49152, 9};
        vecs[11] = '{18'h30000, 9'd1, 17'd16384, 17'd16384, 3'd2, 17'd36864, 9};
        vecs[12] = '{18'h30000, 9'd1, 17'd16384, 17'd16384, 3'd3, 17'd0,     9};
        vecs[13] = '{18'h3FFFF, 9'd1, 17'd32768, 17'd0,     3'd5, 17'd65535, 9};
        vecs[14] = '{18'h28000, 9'd1, 17'd32768, 17'd0,     3'd0, 17'd40960, 9};
        vecs[15] = '{18'h30000, 9'd2, 17'd32768, 17'd0,     3'd6, 17'd36864, 16};
        vecs[16] = '{18'h00000, 9'd1, 17'd1000,  17'd0,     3'd0, 17'd0,     9};
        vecs[17] = '{18'h30000, 9'd1, 17'd0,     17'd0,     3'd2, 17'd0,     9};

        RST = 1'b1; start7 = 1'b0; start1 = 1'b0;
        mu = '0; times = '0; x0_base = '0; x0_step = '0; rd_ch = '0; rd_ch1 = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_busy7", busy7, 0);
        check("reset_done7", done7, 0);
        check("reset_rd7", rd7, 0);
        check("reset_busy1", busy1, 0);
        check("reset_rd1", rd1, 0);
        RST = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < NV; i++) begin
            run7(vecs[i], lat);
            check($sformatf("vec%0d_done_lat", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_busy_at_done", i), busy7, 1);
            @(negedge CLK);
            check($sformatf("vec%0d_idle_after", i), busy7, 0);
            rd_ch = vecs[i].ch;
            #1;
            check($sformatf("vec%0d_rd_data", i), rd7, vecs[i].exp);
            @(negedge CLK);
        end

        // Single-channel trajectory, observing the intermediate sweep
        mu = 18'h30000; times = 9'd2; x0_base = 17'd32768; x0_step = 17'd0;
        start1 = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start1 = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("traj_sweep1", rd1, 49152);
        check("traj_not_done_yet", done1, 0);
        @(negedge CLK);
        check("traj_done_n4", done1, 1);
        check("traj_sweep2", rd1, 36864);
        @(negedge CLK);

        // Start pulsed mid-run with another mu must be ignored
        v = vecs[0];
        mu = v.mu; times = v.times; x0_base = v.base; x0_step = v.step;
        start7 = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start7 = 1'b0;
        dones = 0;
        lat = 1;
        repeat (60) begin
            if (lat == 10) begin
                mu = 18'h30000; times = 9'd1; start7 = 1'b1;
            end else begin
                start7 = 1'b0;
            end
            if (done7) begin
                dones++;
                check("busy_start_done_lat", lat, 37);
            end
            @(negedge CLK);
            lat++;
        end
        start7 = 1'b0;
        check("busy_start_done_count", dones, 1);
        rd_ch = 3'd0; #1;
        check("busy_start_ch0", rd7, 32768);
        rd_ch = 3'd6; #1;
        check("busy_start_ch6", rd7, 32768);

        // Reset in the middle of a run discards it
        @(negedge CLK);
        v = vecs[9];
        mu = v.mu; times = v.times; x0_base = v.base; x0_step = v.step;
        start7 = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start7 = 1'b0;
        repeat (4) @(negedge CLK);
        check("midrun_busy_before_rst", busy7, 1);
        RST = 1'b1;
        start7 = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        start7 = 1'b0;
        check("rst_busy", busy7, 0);
        check("rst_done", done7, 0);
        for (int c = 0; c < 7; c++) begin
            rd_ch = 3'(c); #1;
            check($sformatf("rst_rd_ch%0d", c), rd7, 0);
        end
        dones = 0;
        repeat (30) begin
            @(negedge CLK);
            if (done7) dones++;
        end
        check("rst_no_done", dones, 0);
        run7(vecs[10], lat);
        check("post_rst_lat", lat, 9);
        @(negedge CLK);
        rd_ch = 3'd1; #1;
        check("post_rst_rd", rd7, 49152);

`ifdef LOGISTIC_TRACE_EN
        begin
            int nvalid;
            @(negedge CLK);
            v = vecs[15];
            mu = v.mu; times = v.times; x0_base = v.base; x0_step = 17'd100;
            start7 = 1'b1;
            @(posedge CLK);
            @(negedge CLK);
            start7 = 1'b0;
            nvalid = 0;
            repeat (25) begin
                if (tr_valid) begin
                    check("trace_ch_seq", tr_ch, nvalid % 7);
                    rd_ch = tr_ch; #1;
                    check("trace_data_vs_rd", tr_data, rd7);
                    nvalid++;
                end
                @(negedge CLK);
            end
            check("trace_valid_count", nvalid, 14);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
